// File: rtl/edge_gen_pkg.sv
// ---------------------------------------------------------------------------
// edge_gen_pkg
// Shared types and helpers for the 8-bit toggle generator.
//   EDGE_GEN_W       : bus width (fixed at 8)
//   edge_gen_state_t : generator FSM states
//   popcount8()      : number of set bits in an 8-bit vector
// ---------------------------------------------------------------------------
package edge_gen_pkg;

  localparam int EDGE_GEN_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } edge_gen_state_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/edge_gen_select.sv
// ---------------------------------------------------------------------------
// edge_gen_select
// Combinational bit picker. Walks the mask in index order beginning at
// `start` (wrapping past bit 7) and selects set bits until `limit` bits have
// been taken or the mask is exhausted.
//   mask  [7:0] in  : bits allowed to toggle (never 0 when used in RUN)
//   limit [7:0] in  : maximum number of bits to select
//   start [2:0] in  : first bit index examined
//   sel   [7:0] out : selected bits
//   k     [3:0] out : number of selected bits, min(limit, popcount(mask))
// ---------------------------------------------------------------------------
module edge_gen_select
  import edge_gen_pkg::*;
(
  input  logic [7:0] mask,
  input  logic [7:0] limit,
  input  logic [2:0] start,
  output logic [7:0] sel,
  output logic [3:0] k
);

  // Priority walk from the start pointer, stopping once the limit is reached.
  always_comb begin
    logic [2:0] idx;
    logic [3:0] taken;
    sel   = 8'h00;
    taken = 4'd0;
    idx   = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = start + i[2:0];
      if (mask[idx] && ({4'd0, taken} < limit)) begin
        sel[idx] = 1'b1;
        taken    = taken + 4'd1;
      end else begin
        taken    = taken;
      end
    end
  end

  assign k = popcount8(sel);

endmodule

// File: rtl/edge_8b_toggle_gen.sv
// ---------------------------------------------------------------------------
// edge_8b_toggle_gen
// Accepts a (transition budget, bit mask) request and drives an 8-bit
// registered bus so that exactly the requested number of bit transitions
// occur, at most popcount(mask) per cycle. Keeps a running mod-256 total.
//
// Ports:
//   clk            in  : clock
//   reset          in  : synchronous, active-high reset
//   clear          in  : synchronous clear, same effect as reset
//   req_val        in  : request valid
//   req_rdy        out : request ready (IDLE and not clearing)
//   req_count[7:0] in  : transitions to emit for this request
//   req_mask [7:0] in  : bits allowed to toggle, 8'h00 means 8'hFF
//   out      [7:0] out : generated bus (registered)
//   busy           out : high while in RUN
//   done           out : one-cycle pulse in DONE
//   sent     [7:0] out : transitions emitted since reset/clear, wraps
//
// Configuration macro: EDGE_GEN_ROTATE_EN
//   defined   : a persistent 3-bit start pointer rotates selection priority
//   undefined : lowest-index-first selection, no pointer register
// ---------------------------------------------------------------------------
module edge_8b_toggle_gen
  import edge_gen_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  req_val,
  output logic                  req_rdy,
  input  logic [EDGE_GEN_W-1:0] req_count,
  input  logic [EDGE_GEN_W-1:0] req_mask,
  output logic [EDGE_GEN_W-1:0] out,
  output logic                  busy,
  output logic                  done,
  output logic [EDGE_GEN_W-1:0] sent
);

  edge_gen_state_t r_state;
  logic [7:0]      r_out;
  logic [7:0]      r_rem;
  logic [7:0]      r_mask;
  logic [7:0]      r_sent;

  logic [7:0]      w_sel;
  logic [3:0]      w_k;
  logic [2:0]      w_start;
  logic [7:0]      w_mask_eff;
  logic            w_fire;

`ifdef EDGE_GEN_ROTATE_EN
  logic [2:0]      r_ptr;
  logic [2:0]      w_next_ptr;

  assign w_start = r_ptr;

  // Next pointer is one past the last bit selected in walk order.
  always_comb begin
    logic [2:0] idx;
    w_next_ptr = r_ptr;
    idx        = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx        = r_ptr + i[2:0];
      w_next_ptr = w_sel[idx] ? (idx + 3'd1) : w_next_ptr;
    end
  end
`else
  assign w_start = 3'd0;
`endif

  assign w_mask_eff = (req_mask == 8'h00) ? 8'hFF : req_mask;
  assign req_rdy    = (r_state == IDLE) && !clear;
  assign w_fire     = req_val && req_rdy;

  // Selection limited by the remaining budget; r_mask is never zero in RUN.
  edge_gen_select u_select (
    .mask  (r_mask),
    .limit (r_rem),
    .start (w_start),
    .sel   (w_sel),
    .k     (w_k)
  );

  // FSM, bus, budget and running-total registers; clear behaves like reset.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state <= IDLE;
      r_out   <= 8'h00;
      r_rem   <= 8'h00;
      r_mask  <= 8'h00;
      r_sent  <= 8'h00;
`ifdef EDGE_GEN_ROTATE_EN
      r_ptr   <= 3'd0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_fire) begin
            r_mask  <= w_mask_eff;
            r_rem   <= req_count;
            r_state <= (req_count != 8'h00) ? RUN : DONE;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_out  <= r_out ^ w_sel;
          r_rem  <= r_rem - {4'd0, w_k};
          r_sent <= r_sent + {4'd0, w_k};
`ifdef EDGE_GEN_ROTATE_EN
          r_ptr  <= w_next_ptr;
`endif
          r_state <= (r_rem == {4'd0, w_k}) ? DONE : RUN;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign out  = r_out;
  assign sent = r_sent;
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

endmodule
